// File: rtl/retro16_pkg.sv
// Shared types and constants for the interrupt bank sequencer.
// Optional feature macro: IRQ_EDGE_EN (edge-latched interrupt request).
package retro16_pkg;

  typedef enum logic [1:0] {
    RUN_THREAD = 2'd0,
    ENTER      = 2'd1,
    RUN_ISR    = 2'd2,
    LEAVE      = 2'd3
  } irq_state_t;

  localparam logic [15:0] DEFAULT_VECTOR = 16'h0010;
  localparam int          PC_REG_IDX     = 6;

endpackage

// File: rtl/irq_bank_ctrl_pending.sv
// Pending-request source for irq_bank_ctrl.
// IRQ_EDGE_EN: rising-edge latch cleared on ack; otherwise level bypass.
module irq_pending_latch (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic ack,
  output logic pending
);

`ifdef IRQ_EDGE_EN
  logic irq_prev;
  logic pend_q;

  // Edge detect; a new edge wins over a same-cycle ack clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_prev <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      irq_prev <= irq;
      pend_q   <= (irq & ~irq_prev) | (pend_q & ~ack);
    end
  end

  assign pending = pend_q;
`else
  logic unused_in;
  assign unused_in = ^{clk, rst, ack};
  assign pending   = irq;
`endif

endmodule

// File: rtl/irq_bank_ctrl.sv
// Interrupt entry/exit sequencer: bank switch, ISR vector load, stall.
// Optional feature macro: IRQ_EDGE_EN (see irq_pending_latch).
module irq_bank_ctrl
  import retro16_pkg::*;
#(
  parameter logic [15:0] VECTOR_ADDR = DEFAULT_VECTOR,
  parameter logic        ISR_BANK    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq,
  input  logic        irq_enable,
  input  logic        instr_boundary,
  input  logic        reti,
  output logic        active_bank,
  output logic [15:0] pc_register_in,
  output logic        pc_write_en,
  output logic        core_stall,
  output logic        irq_ack,
  output logic        in_isr
);

  irq_state_t state_q;
  irq_state_t state_d;
  logic       pending;
  logic       take;
  logic       ret;

  irq_pending_latch u_pend (
    .clk     (clk),
    .rst     (rst),
    .irq     (irq),
    .ack     (irq_ack),
    .pending (pending)
  );

  assign take = pending & irq_enable & instr_boundary
              & (state_q == RUN_THREAD);
  assign ret  = reti & instr_boundary
              & (state_q == RUN_ISR);

  // State register; reset aborts any switch in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN_THREAD;
    else     state_q <= state_d;
  end

  // Next state: one-cycle ENTER/LEAVE, return beats new request
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN_THREAD: if (take) state_d = ENTER;
      ENTER:      state_d = RUN_ISR;
      RUN_ISR:    if (ret) state_d = LEAVE;
      LEAVE:      state_d = RUN_THREAD;
      default:    state_d = RUN_THREAD;
    endcase
  end

  // Output decode; bank follows the registered state
  always_comb begin
    active_bank    = ~ISR_BANK;
    pc_register_in = 16'h0000;
    pc_write_en    = 1'b0;
    core_stall     = 1'b0;
    in_isr         = 1'b1;
    irq_ack        = take & ~rst;
    unique case (state_q)
      RUN_THREAD: in_isr = 1'b0;
      ENTER: begin
        active_bank    = ISR_BANK;
        pc_register_in = VECTOR_ADDR;
        pc_write_en    = 1'b1;
        core_stall     = 1'b1;
      end
      RUN_ISR: active_bank = ISR_BANK;
      LEAVE:   core_stall  = 1'b1;
      default: in_isr = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_irq_bank_ctrl.sv
// Self-checking bench for irq_bank_ctrl.
// Expectations for the pulse test depend on IRQ_EDGE_EN.
module tb_irq_bank_ctrl;

  logic        clk;
  logic        rst;
  logic        irq;
  logic        irq_enable;
  logic        instr_boundary;
  logic        reti;
  logic        active_bank;
  logic [15:0] pc_register_in;
  logic        pc_write_en;
  logic        core_stall;
  logic        irq_ack;
  logic        in_isr;

  int total;
  int bad;

  logic [15:0] rf0;
  logic [15:0] rf1;

  typedef struct {
    logic        irq;
    logic        en;
    logic        bnd;
    logic        reti;
    logic        ack;
    logic        bank;
    logic        we;
    logic        stall;
    logic        isr;
    logic [15:0] pc;
  } vec_t;

  vec_t vt [11];

  irq_bank_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .irq            (irq),
    .irq_enable     (irq_enable),
    .instr_boundary (instr_boundary),
    .reti           (reti),
    .active_bank    (active_bank),
    .pc_register_in (pc_register_in),
    .pc_write_en    (pc_write_en),
    .core_stall     (core_stall),
    .irq_ack        (irq_ack),
    .in_isr         (in_isr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tiny R6 model: thread bank preloaded with the thread PC
  always @(posedge clk) begin
    if (rst) begin
      rf0 <= 16'h1234;
      rf1 <= 16'h0000;
    end else if (pc_write_en) begin
      if (active_bank) rf1 <= pc_register_in;
      else             rf0 <= pc_register_in;
    end
  end

  task automatic chk(input string n, input int row,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h",
               n, row, got, exp);
    end
  endtask

  task automatic drive(input logic i, input logic e,
                       input logic b, input logic r);
    irq            = i;
    irq_enable     = e;
    instr_boundary = b;
    reti           = r;
    #2;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string n, input int row,
                         input logic a, input logic bk,
                         input logic we, input logic st,
                         input logic is, input logic [15:0] pc);
    chk({n, ".ack"},   row, {15'd0, irq_ack},     {15'd0, a});
    chk({n, ".bank"},  row, {15'd0, active_bank}, {15'd0, bk});
    chk({n, ".we"},    row, {15'd0, pc_write_en}, {15'd0, we});
    chk({n, ".stall"}, row, {15'd0, core_stall},  {15'd0, st});
    chk({n, ".isr"},   row, {15'd0, in_isr},      {15'd0, is});
    chk({n, ".pc"},    row, pc_register_in,       pc);
  endtask

  initial begin
    int acks;
    logic exp_pulse;
    total = 0;
    bad   = 0;
`ifdef IRQ_EDGE_EN
    exp_pulse = 1'b1;
`else
    exp_pulse = 1'b0;
`endif

    //          irq en bnd reti ack bank we st isr pc
    vt[0]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0000};
    vt[1]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000};
    vt[2]  = '{1, 1, 1, 0, 1, 0, 0, 0, 0, 16'h0000};
    vt[3]  = '{0, 1, 0, 0, 0, 1, 1, 1, 1, 16'h0010};
    vt[4]  = '{0, 1, 1, 0, 0, 1, 0, 0, 1, 16'h0000};
    vt[5]  = '{0, 1, 0, 1, 0, 1, 0, 0, 1, 16'h0000};
    vt[6]  = '{0, 1, 1, 1, 0, 1, 0, 0, 1, 16'h0000};
    vt[7]  = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 16'h0000};
    vt[8]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000};
    vt[9]  = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 16'h0000};
    vt[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000};

    rst = 1'b1;
    drive(0, 0, 0, 0);
    adv();
    adv();
    chk_all("reset", 0, 0, 0, 0, 0, 0, 16'h0000);
    rst = 1'b0;
    adv();

    // Full entry/return walk from the table
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].irq, vt[i].en, vt[i].bnd, vt[i].reti);
      chk_all("vec", i, vt[i].ack, vt[i].bank, vt[i].we,
              vt[i].stall, vt[i].isr, vt[i].pc);
      adv();
    end
    chk("rf_thread_r6", 0, rf0, 16'h1234);
    chk("rf_isr_r6",    0, rf1, 16'h0010);

    // Enable low holds the request over 20 boundaries
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 1, 0);
      if (irq_ack) acks++;
      adv();
    end
    chk("masked_acks", 0, acks[15:0], 16'd0);
    drive(1, 1, 1, 0);
    chk("unmask_ack", 0, {15'd0, irq_ack}, 16'd1);
    adv();
    drive(0, 1, 0, 0);
    chk_all("enter", 1, 0, 1, 1, 1, 1, 16'h0010);
    adv();
    drive(0, 1, 0, 0);
    chk_all("isr", 1, 0, 1, 0, 0, 1, 16'h0000);
    adv();
    drive(0, 1, 1, 1);
    adv();
    drive(0, 1, 0, 0);
    chk_all("leave", 1, 0, 0, 0, 1, 1, 16'h0000);
    adv();
    drive(0, 1, 0, 0);
    chk_all("back", 1, 0, 0, 0, 0, 0, 16'h0000);
    chk("rf_thread_ret", 1, rf0, 16'h1234);
    adv();

    // Return and new request on the same boundary
    drive(1, 1, 0, 0);
    adv();
    drive(1, 1, 1, 0);
    chk("t5_entry_ack", 0, {15'd0, irq_ack}, 16'd1);
    adv();
    drive(0, 1, 0, 0);
    adv();
    drive(0, 1, 1, 0);
    adv();
    acks = 0;
    drive(1, 1, 1, 1);
    if (irq_ack) acks++;
    adv();
    drive(1, 1, 1, 0);
    if (irq_ack) acks++;
    chk("t5_leave_stall", 0, {15'd0, core_stall}, 16'd1);
    adv();
    drive(1, 1, 1, 0);
    chk("t5_reentry_ack", 0, {15'd0, irq_ack}, 16'd1);
    chk("t5_thread_isr", 0, {15'd0, in_isr}, 16'd0);
    if (irq_ack) acks++;
    adv();
    drive(0, 1, 1, 0);
    if (irq_ack) acks++;
    chk("t5_enter_bank", 0, {15'd0, active_bank}, 16'd1);
    adv();
    chk("t5_ack_count", 0, acks[15:0], 16'd1);
    drive(0, 1, 1, 1);
    adv();
    drive(0, 1, 0, 0);
    adv();
    drive(0, 1, 0, 0);
    chk("t5_done_isr", 0, {15'd0, in_isr}, 16'd0);
    adv();

    // One-cycle pulse off a boundary
    drive(1, 1, 0, 0);
    chk("t6_pulse_ack", 0, {15'd0, irq_ack}, 16'd0);
    adv();
    drive(0, 1, 1, 0);
    chk("t6_late_ack", 0, {15'd0, irq_ack}, {15'd0, exp_pulse});
    adv();
    if (exp_pulse) begin
      drive(0, 1, 0, 0);
      adv();
      drive(0, 1, 1, 1);
      adv();
      drive(0, 1, 0, 0);
      adv();
    end
    drive(0, 1, 0, 0);
    chk("t6_idle_isr", 0, {15'd0, in_isr}, 16'd0);
    adv();

    // Async reset in the middle of ENTER
    drive(1, 1, 0, 0);
    adv();
    drive(1, 1, 1, 0);
    chk("t1_ack", 0, {15'd0, irq_ack}, 16'd1);
    adv();
    drive(0, 1, 0, 0);
    chk("t1_in_enter", 0, {15'd0, pc_write_en}, 16'd1);
    rst = 1'b1;
    #1;
    chk_all("mid_rst", 0, 0, 0, 0, 0, 0, 16'h0000);
    adv();
    rst = 1'b0;
    adv();
    drive(0, 1, 1, 0);
    chk_all("post_rst", 0, 0, 0, 0, 0, 0, 16'h0000);
    adv();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
